// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// Bus between the EX/MEM pipeline stage, the memory-stage controller and the multi-cycle data memory.
interface mem_stage_ctrl_if;
  logic        valid_in;
  logic        DMemEn_in;
  logic        DMemWrite_in;
  logic        DMemDump_in;
  logic [15:0] addr_in;
  logic [15:0] writeData_in;
  logic [15:0] mem_Addr;
  logic [15:0] mem_DataIn;
  logic        mem_Rd;
  logic        mem_Wr;
  logic        mem_createdump;
  logic [15:0] mem_DataOut;
  logic        mem_Done;
  logic        mem_Stall;
  logic        stall_out;
  logic [15:0] readData_out;
  logic        err_out;
  logic        halted_out;

  modport master (
    output valid_in, DMemEn_in, DMemWrite_in, DMemDump_in, addr_in, writeData_in,
           mem_DataOut, mem_Done, mem_Stall,
    input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr, mem_createdump,
           stall_out, readData_out, err_out, halted_out
  );

  modport slave (
    input  valid_in, DMemEn_in, DMemWrite_in, DMemDump_in, addr_in, writeData_in,
           mem_DataOut, mem_Done, mem_Stall,
    output mem_Addr, mem_DataIn, mem_Rd, mem_Wr, mem_createdump,
           stall_out, readData_out, err_out, halted_out
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// mem_stage_ctrl: sequences pipeline loads/stores/dumps onto a multi-cycle data memory,
// freezing the pipeline until each access completes.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_ctrl_if.slave  bus
);
  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] waitCnt;
  logic [15:0] addrReg;
  logic [15:0] dataReg;
  logic [15:0] readReg;
  logic        pendLoad;
  logic        errReg;

  logic accessReq, dumpReq, inIdle, inWait;
  logic issue, dumpFire, busyStall, misalignErr, timedOut, loadDone;

  assign accessReq = bus.valid_in & bus.DMemEn_in & ~bus.DMemDump_in & ~bus.halted_out;
  assign dumpReq   = bus.valid_in & bus.DMemDump_in & ~bus.halted_out;

  // Reset gates every same-cycle decision so no strobe or stall escapes while rst is high.
  assign inIdle = (state == IDLE) & ~rst;
  assign inWait = (state == WAIT) & ~rst;

  assign misalignErr = inIdle & accessReq & bus.addr_in[0];
  assign issue       = inIdle & accessReq & ~bus.addr_in[0] & ~bus.mem_Stall;
  assign dumpFire    = inIdle & dumpReq & ~bus.mem_Stall;
  assign busyStall   = inIdle & ((accessReq & ~bus.addr_in[0]) | dumpReq) & bus.mem_Stall;
  assign timedOut    = inWait & ~bus.mem_Done & (waitCnt == TIMEOUT_CNT);
  assign loadDone    = bus.mem_Done & ((issue & ~bus.DMemWrite_in) | (inWait & pendLoad));

  assign bus.mem_Rd         = issue & ~bus.DMemWrite_in;
  assign bus.mem_Wr         = issue & bus.DMemWrite_in;
  assign bus.mem_createdump = dumpFire;
  assign bus.mem_Addr       = issue ? bus.addr_in : addrReg;
  assign bus.mem_DataIn     = issue ? bus.writeData_in : dataReg;
  // Stall drops in the completion (or timeout) cycle so the held stage advances exactly once.
  assign bus.stall_out      = busyStall | (issue & ~bus.mem_Done) |
                              (inWait & ~bus.mem_Done & ~timedOut);
  assign bus.readData_out   = loadDone ? bus.mem_DataOut : readReg;
  assign bus.err_out        = errReg;
  assign bus.halted_out     = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= 16'd0;
      addrReg  <= 16'd0;
      dataReg  <= 16'd0;
      readReg  <= 16'd0;
      pendLoad <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      if (loadDone) begin
        readReg <= bus.mem_DataOut;
      end
      if (misalignErr | timedOut) begin
        errReg <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (dumpFire) begin
            state <= HALT;
          end else if (issue) begin
            addrReg  <= bus.addr_in;
            dataReg  <= bus.writeData_in;
            pendLoad <= ~bus.DMemWrite_in;
            if (!bus.mem_Done) begin
              state   <= WAIT;
              waitCnt <= 16'd0;
            end
          end
        end
        WAIT: begin
          if (bus.mem_Done || (waitCnt == TIMEOUT_CNT)) begin
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
